ksa_multiword_sequencer: RTL and testbench

// - Sequences one shared 16-bit Kogge-Stone adder over a WORDS*16-bit add, one 16-bit chunk per clock, LS chunk first.
// - Chains the carry between chunks and returns the full sum, carry-out and signed overflow on a valid/ready handshake.
// - Sits between operand producers and a single instantiated 16-bit KSA. The adder is purely combinational and lives outside this block.

---
 rtl/ksa_multiword_sequencer.sv | 87 ++++++++
 tb/tb_ksa_multiword_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ksa_multiword_sequencer.sv
// ksa_multiword_sequencer: runs an external 16-bit KSA chunk by chunk over a WORDS*16-bit add.
// Optional KSA_SEQ_SUB_EN adds a Sub port so the block can also compute A - B.
module ksa_multiword_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef KSA_SEQ_SUB_EN
    input  logic                  Sub,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   A,
    input  logic [16*WORDS-1:0]   B,
    input  logic                  Cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   Sum,
    output logic                  Cout,
    output logic                  Ovf,
    output logic [15:0]           ksa_a,
    output logic [15:0]           ksa_b,
    output logic                  ksa_cin,
    input  logic [15:0]           ksa_sum,
    input  logic                  ksa_cout
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            w_last, w_run, w_sub;

`ifdef KSA_SEQ_SUB_EN
    assign w_sub = Sub;
`else
    assign w_sub = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_last    = r_idx == IW'(WORDS - 1);
        w_run     = r_state == RUN;
        w_next    = r_state == IDLE ? (in_valid ? RUN : IDLE) :
                    r_state == RUN  ? (w_last ? DONE : RUN) :
                                      (out_ready ? IDLE : DONE);
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        ksa_a     = w_run ? r_a[16*r_idx +: 16] : 16'h0;
        ksa_b     = w_run ? r_b[16*r_idx +: 16] : 16'h0;
        ksa_cin   = w_run ? r_carry : 1'b0;
    end

    // Subtraction folds into the add as A + ~B + 1, so the run loop never needs to know.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a     <= A;
            r_b     <= w_sub ? ~B : B;
            r_carry <= w_sub ? 1'b1 : Cin;
            r_idx   <= '0;
        end else if (w_run) begin
            Sum[16*r_idx +: 16] <= ksa_sum;
            r_carry             <= ksa_cout;
            r_idx               <= r_idx + 1'b1;
            if (w_last) begin
                Cout <= ksa_cout;
                Ovf  <= (r_a[W-1] == r_b[W-1]) && (ksa_sum[15] != r_a[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_ksa_multiword_sequencer.sv
// tb_ksa_multiword_sequencer: random and directed ops against a plain-arithmetic reference.
// Define KSA_SEQ_SUB_EN for both files to exercise subtraction.
module tb_ksa_multiword_sequencer;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, Cin = 0, Sub = 0;
    logic [63:0] A = 0, B = 0, Sum;
    logic        in_ready, out_valid, Cout, Ovf, ksa_cin, ksa_cout;
    logic [15:0] ksa_a, ksa_b, ksa_sum;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    assign {ksa_cout, ksa_sum} = {1'b0, ksa_a} + {1'b0, ksa_b} + {16'h0, ksa_cin};

    ksa_multiword_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst(rst),
`ifdef KSA_SEQ_SUB_EN
        .Sub(Sub),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ovf(Ovf),
        .ksa_a(ksa_a), .ksa_b(ksa_b), .ksa_cin(ksa_cin), .ksa_sum(ksa_sum), .ksa_cout(ksa_cout)
    );

    task automatic chk(input string tag, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                          input logic s, input int hold);
        logic [64:0] full;
        logic [63:0] eb;
        logic        ec, eovf;
        int          n;
        eb   = s ? ~b : b;
        ec   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, eb} + {64'h0, ec};
        eovf = (a[63] == eb[63]) && (full[63] != a[63]);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_before", {64'h0, in_ready}, 65'd1);
        @(negedge clk);
        A = a; B = b; Cin = c; Sub = s; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'($urandom); Sub = 1'($urandom);
        chk("ksa_a_chunk0", {49'h0, ksa_a}, {49'h0, a[15:0]});
        chk("ksa_cin_chunk0", {64'h0, ksa_cin}, {64'h0, ec});
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", 65'(n), 65'd4);
        chk("sum", {1'b0, Sum}, {1'b0, full[63:0]});
        chk("cout", {64'h0, Cout}, {64'h0, full[64]});
        chk("ovf", {64'h0, Ovf}, {64'h0, eovf});
        chk("ksa_a_done", {49'h0, ksa_a}, 65'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {64'h0, out_valid}, 65'd1);
            chk("hold_ready", {64'h0, in_ready}, 65'd0);
            chk("hold_sum", {Cout, Sum}, full);
            chk("hold_ovf", {64'h0, Ovf}, {64'h0, eovf});
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("valid_drop", {64'h0, out_valid}, 65'd0);
        chk("ready_back", {64'h0, in_ready}, 65'd1);
    endtask

    initial begin
        logic s;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {64'h0, in_ready}, 65'd1);
        chk("rst_out_valid", {64'h0, out_valid}, 65'd0);
        chk("rst_sum", {Cout, Sum}, 65'd0);
        chk("rst_ovf", {64'h0, Ovf}, 65'd0);
        chk("rst_ksa", {32'h0, ksa_a, ksa_b, ksa_cin}, 65'd0);
        rst = 0;

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 2);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 10);
`ifdef KSA_SEQ_SUB_EN
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1);
`endif

        @(negedge clk);
        A = 64'h0000_FFFF_FFFF_FFFF; B = 64'h1; Cin = 0; Sub = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_in_ready", {64'h0, in_ready}, 65'd1);
        chk("abort_sum", {1'b0, Sum}, 65'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {64'h0, out_valid}, 65'd0);
        end
        run_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0000_0001_0001, 1'b0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 4 == 1) ra = {ra[63:16], 16'hFFFF};
            if (k % 4 == 2) rb = ~ra;
`ifdef KSA_SEQ_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom), s, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
